// File: rtl/lcd_cmd_sched.sv
// lcd_cmd_sched: round-robin command scheduler in front of the LCD image
// controller. Two requesters share one command port through a small FIFO.
// Commands are issued as single-cycle strobes, with at least one idle cycle
// between strobes, and only while the controller is not busy. A WRITE
// command (code 0) ends the sequence. After the controller's done the block
// reports sched_done until reset.
// Optional feature: define LCD_SCHED_STATS_EN to enable the saturating
// issued-command counter on cmd_cnt. When it is undefined, cmd_cnt reads 0.
module lcd_cmd_sched #(
  parameter int DEPTH = 4,
  parameter int CMD_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_a,
  input  logic [CMD_W-1:0] cmd_a,
  output logic             gnt_a,
  input  logic             req_b,
  input  logic [CMD_W-1:0] cmd_b,
  output logic             gnt_b,
  input  logic             lcd_busy,
  input  logic             lcd_done,
  output logic [CMD_W-1:0] cmd,
  output logic             cmd_valid,
  output logic             fifo_full,
  output logic             sched_done,
  output logic [7:0]       cmd_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CMD_W-1:0] DROP_MIN = CMD_W'(12);
  localparam logic LAST_A = 1'b0;
  localparam logic LAST_B = 1'b1;

  typedef enum logic [1:0] {S_IDLE, S_GAP, S_WAIT_DONE, S_FINISHED} state_t;

  state_t           state_q, state_d;
  logic [CMD_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             write_seen_q, write_seen_d;
  logic             last_q, last_d;
  logic [CMD_W-1:0] cmd_q, cmd_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic             fifo_full_q, fifo_full_d;
  logic             sched_done_q, sched_done_d;

  logic             win_open;
  logic             gnt_a_c, gnt_b_c;
  logic             push, pop;
  logic [CMD_W-1:0] grant_cmd;
  logic [CMD_W-1:0] head;

  assign head = mem_q[rd_ptr_q];

  // Accept window and round-robin grant; gated by reset so grants read 0 while it is held
  always_comb begin
    win_open  = reset_n && (count_q < DEPTH_C) && !write_seen_q && (state_q != S_FINISHED);
    gnt_a_c   = 1'b0;
    gnt_b_c   = 1'b0;
    if (win_open) begin
      if (req_a && req_b) begin
        if (last_q == LAST_B) gnt_a_c = 1'b1;
        else                  gnt_b_c = 1'b1;
      end else if (req_a) begin
        gnt_a_c = 1'b1;
      end else if (req_b) begin
        gnt_b_c = 1'b1;
      end
    end
    grant_cmd = gnt_a_c ? cmd_a : cmd_b;
    // Codes 12..15 are consumed by the grant but never stored
    push      = (gnt_a_c || gnt_b_c) && (grant_cmd < DROP_MIN);
  end

  assign gnt_a = gnt_a_c;
  assign gnt_b = gnt_b_c;

  // FIFO storage write port; contents need no reset because count/pointers define validity
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= grant_cmd;
  end

  // Next-state logic for the issue FSM, FIFO bookkeeping and registered outputs
  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    cmd_valid_d  = 1'b0;
    sched_done_d = sched_done_q;
    pop          = 1'b0;

    case (state_q)
      S_IDLE: begin
        if ((count_q != '0) && !lcd_busy) begin
          pop         = 1'b1;
          cmd_d       = head;
          cmd_valid_d = 1'b1;
          state_d     = (head == '0) ? S_WAIT_DONE : S_GAP;
        end
      end
      S_GAP: begin
        state_d = S_IDLE;
      end
      S_WAIT_DONE: begin
        // Raise sched_done together with the move so it is visible the cycle after done
        if (lcd_done) begin
          state_d      = S_FINISHED;
          sched_done_d = 1'b1;
        end
      end
      S_FINISHED: begin
        sched_done_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    wr_ptr_d = push ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);

    // A finished sequence discards anything left queued
    if (state_q == S_FINISHED) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end

    fifo_full_d  = (count_d == DEPTH_C);
    write_seen_d = write_seen_q || (push && (grant_cmd == '0));

    last_d = last_q;
    if (gnt_a_c)      last_d = LAST_A;
    else if (gnt_b_c) last_d = LAST_B;
  end

  // State register with asynchronous clear of the whole sequence
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      write_seen_q <= 1'b0;
      last_q       <= LAST_B;
      cmd_q        <= '0;
      cmd_valid_q  <= 1'b0;
      fifo_full_q  <= 1'b0;
      sched_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      write_seen_q <= write_seen_d;
      last_q       <= last_d;
      cmd_q        <= cmd_d;
      cmd_valid_q  <= cmd_valid_d;
      fifo_full_q  <= fifo_full_d;
      sched_done_q <= sched_done_d;
    end
  end

  assign cmd        = cmd_q;
  assign cmd_valid  = cmd_valid_q;
  assign fifo_full  = fifo_full_q;
  assign sched_done = sched_done_q;

`ifdef LCD_SCHED_STATS_EN
  logic [7:0] cnt_q, cnt_d;

  // Count issue strobes, including WRITE, saturating at 255
  always_comb begin
    cnt_d = cnt_q;
    if (cmd_valid_d && (cnt_q != 8'hFF)) cnt_d = cnt_q + 8'd1;
  end

  // Counter register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= 8'd0;
    else          cnt_q <= cnt_d;
  end

  assign cmd_cnt = cnt_q;
`else
  assign cmd_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_lcd_cmd_sched.sv
// Self-checking bench for lcd_cmd_sched.
// Grant expectations come from a vector table. Commands expected on the
// controller port go into a scoreboard queue when they are driven. A
// negedge monitor pops that queue on every cmd_valid strobe.
module tb_lcd_cmd_sched;

  logic       clk;
  logic       reset_n;
  logic       req_a, req_b;
  logic [3:0] cmd_a, cmd_b;
  logic       gnt_a, gnt_b;
  logic       lcd_busy, lcd_done;
  logic [3:0] cmd;
  logic       cmd_valid, fifo_full, sched_done;
  logic [7:0] cmd_cnt;

  lcd_cmd_sched #(.DEPTH(4), .CMD_W(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_a      (req_a),
    .cmd_a      (cmd_a),
    .gnt_a      (gnt_a),
    .req_b      (req_b),
    .cmd_b      (cmd_b),
    .gnt_b      (gnt_b),
    .lcd_busy   (lcd_busy),
    .lcd_done   (lcd_done),
    .cmd        (cmd),
    .cmd_valid  (cmd_valid),
    .fifo_full  (fifo_full),
    .sched_done (sched_done),
    .cmd_cnt    (cmd_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ra;
    logic [3:0] ca;
    logic       rb;
    logic [3:0] cb;
    logic       busy;
    logic       ega;
    logic       egb;
  } vec_t;

  vec_t     tbl [14];
  int       n_cmp = 0;
  int       n_bad = 0;
  int       sb [$];
  int       cyc = 0;
  int       last_pulse = -1;
  int       exp_cnt = 0;
  bit       strict_gap = 1'b0;
  int       cnt_exp_const;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every strobe must match the oldest expected command
  always @(negedge clk) begin : mon
    int e;
    if (reset_n === 1'b1 && cmd_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_issue", int'(cmd_valid), 0);
      end else begin
        e = sb.pop_front();
        chk("issue_cmd", int'(cmd), e);
        if (last_pulse >= 0) chk("issue_gap_ge2", int'((cyc - last_pulse) >= 2), 1);
        if (strict_gap && last_pulse >= 0) chk("issue_gap_eq2", cyc - last_pulse, 2);
`ifdef LCD_SCHED_STATS_EN
        if (exp_cnt < 255) exp_cnt++;
`endif
        chk("cmd_cnt_on_issue", int'(cmd_cnt), exp_cnt);
      end
      $display("issue cmd=%0d cyc=%0d", cmd, cyc);
      last_pulse = cyc;
    end
  end

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      req_a    = tbl[i].ra;
      cmd_a    = tbl[i].ca;
      req_b    = tbl[i].rb;
      cmd_b    = tbl[i].cb;
      lcd_busy = tbl[i].busy;
      #1;
      chk($sformatf("gnt_a[%0d]", i), int'(gnt_a), int'(tbl[i].ega));
      chk($sformatf("gnt_b[%0d]", i), int'(gnt_b), int'(tbl[i].egb));
      if (tbl[i].ega && tbl[i].ca < 4'd12) sb.push_back(int'(tbl[i].ca));
      else if (tbl[i].egb && tbl[i].cb < 4'd12) sb.push_back(int'(tbl[i].cb));
      $display("vec %0d ra=%0b ca=%0d rb=%0b cb=%0d busy=%0b gnt=%0b%0b", i,
               tbl[i].ra, tbl[i].ca, tbl[i].rb, tbl[i].cb, tbl[i].busy, gnt_a, gnt_b);
      tick();
    end
    req_a = 1'b0;
    req_b = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) tick();
    chk({"drain_", name}, sb.size(), 0);
  endtask

  task automatic clear_model();
    sb.delete();
    exp_cnt    = 0;
    last_pulse = -1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef LCD_SCHED_STATS_EN
    cnt_exp_const = 1;
`else
    cnt_exp_const = 0;
`endif
    //         ra    ca     rb    cb     busy  ega   egb
    tbl[0]  = '{1'b0, 4'd0,  1'b1, 4'd13, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{1'b1, 4'd1,  1'b1, 4'd2,  1'b0, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 4'd1,  1'b1, 4'd2,  1'b0, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 4'd1,  1'b1, 4'd2,  1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 4'd1,  1'b1, 4'd2,  1'b0, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 4'd5,  1'b0, 4'd0,  1'b1, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 4'd6,  1'b0, 4'd0,  1'b1, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 4'd7,  1'b0, 4'd0,  1'b1, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 4'd8,  1'b0, 4'd0,  1'b1, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 4'd9,  1'b1, 4'd10, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 4'd7,  1'b0, 4'd0,  1'b0, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 4'd0,  1'b0, 4'd0,  1'b0, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 4'd0,  1'b1, 4'd3,  1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 4'd2,  1'b1, 4'd3,  1'b0, 1'b0, 1'b0};

    // Reset values, with requests present while reset is held
    reset_n  = 1'b0;
    req_a    = 1'b1;  cmd_a = 4'd3;
    req_b    = 1'b1;  cmd_b = 4'd4;
    lcd_busy = 1'b0;  lcd_done = 1'b0;
    #23;
    chk("rst_gnt_a", int'(gnt_a), 0);
    chk("rst_gnt_b", int'(gnt_b), 0);
    chk("rst_cmd", int'(cmd), 0);
    chk("rst_cmd_valid", int'(cmd_valid), 0);
    chk("rst_fifo_full", int'(fifo_full), 0);
    chk("rst_sched_done", int'(sched_done), 0);
    chk("rst_cmd_cnt", int'(cmd_cnt), 0);
    req_a = 1'b0;
    req_b = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();

    // Single command latency: grant at T, strobe registered at the end of T+1
    req_a = 1'b1; cmd_a = 4'd4;
    #1;
    chk("t1_gnt_a", int'(gnt_a), 1);
    sb.push_back(4);
    tick();
    req_a = 1'b0;
    chk("t1_valid_T", int'(cmd_valid), 0);
    tick();
    chk("t1_valid_T1", int'(cmd_valid), 1);
    chk("t1_cmd_T1", int'(cmd), 4);
    chk("t1_cnt_T1", int'(cmd_cnt), cnt_exp_const);
    tick();
    chk("t1_valid_off", int'(cmd_valid), 0);
    chk("t1_cmd_hold", int'(cmd), 4);

    // Dropped code: grant without any issue or count change
    run_vecs(0, 0);
    repeat (4) tick();
    chk("t4_cnt_unchanged", int'(cmd_cnt), cnt_exp_const);

    // Continuous contention alternates A,B,A,B
    run_vecs(1, 4);
    wait_drain("alt", 40);
    tick(); tick();

    // Busy controller: fill the FIFO, refuse a fifth, then drain in order
    run_vecs(5, 7);
    chk("t3_not_full_3", int'(fifo_full), 0);
    run_vecs(8, 8);
    chk("t3_full_4", int'(fifo_full), 1);
    run_vecs(9, 9);
    lcd_busy = 1'b1;
    tick(); tick();
    chk("t3_held_no_issue", int'(cmd_valid), 0);
    last_pulse = -1;
    strict_gap = 1'b1;
    lcd_busy   = 1'b0;
    wait_drain("busy", 40);
    strict_gap = 1'b0;
    tick(); tick();

    // WRITE ends acceptance; done yields sticky sched_done one cycle later
    run_vecs(10, 13);
    wait_drain("write", 40);
    tick(); tick();
    chk("t5_done_pre", int'(sched_done), 0);
    req_b = 1'b1; cmd_b = 4'd3;
    #1;
    chk("t5_b_blocked", int'(gnt_b), 0);
    req_b = 1'b0;
    lcd_done = 1'b1;
    tick();
    lcd_done = 1'b0;
    chk("t5_done_next", int'(sched_done), 1);
    repeat (3) tick();
    chk("t5_done_sticky", int'(sched_done), 1);
    req_a = 1'b1; cmd_a = 4'd5;
    #1;
    chk("t5_finished_no_gnt", int'(gnt_a), 0);
    req_a = 1'b0;

    // Fresh sequence: reach WAIT_DONE, then reset asynchronously
    reset_n = 1'b0;
    #1;
    clear_model();
    tick(); tick();
    reset_n = 1'b1;
    tick();
    req_a = 1'b1; cmd_a = 4'd0;
    #1;
    chk("t6_gnt_write", int'(gnt_a), 1);
    sb.push_back(0);
    tick();
    req_a = 1'b0;
    wait_drain("t6_write", 20);
    tick();
    chk("t6_wait_done_pre", int'(sched_done), 0);
    reset_n = 1'b0;
    req_a = 1'b1; cmd_a = 4'd2;
    #1;
    chk("t6_rst_gnt", int'(gnt_a), 0);
    chk("t6_rst_valid", int'(cmd_valid), 0);
    chk("t6_rst_cmd", int'(cmd), 0);
    chk("t6_rst_done", int'(sched_done), 0);
    chk("t6_rst_cnt", int'(cmd_cnt), 0);
    req_a = 1'b0;
    clear_model();
    tick();
    reset_n = 1'b1;
    lcd_done = 1'b1;
    tick();
    lcd_done = 1'b0;
    tick();
    chk("t6_done_ignored_idle", int'(sched_done), 0);

    // Full FIFO lost on asynchronous reset
    lcd_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_a = 1'b1; cmd_a = 4'(3 + i);
      #1;
      chk($sformatf("t6b_gnt[%0d]", i), int'(gnt_a), 1);
      sb.push_back(3 + i);
      tick();
    end
    req_a = 1'b0;
    chk("t6b_full", int'(fifo_full), 1);
    reset_n = 1'b0;
    #1;
    chk("t6b_rst_full", int'(fifo_full), 0);
    clear_model();
    tick();
    reset_n  = 1'b1;
    lcd_busy = 1'b0;
    repeat (8) tick();
    chk("t6b_no_leftover", int'(cmd_valid), 0);

    // After reset the pointer favours A on a tie, then B
    req_a = 1'b1; cmd_a = 4'd9;
    req_b = 1'b1; cmd_b = 4'd10;
    #1;
    chk("t7_tie1_a", int'(gnt_a), 1);
    chk("t7_tie1_b", int'(gnt_b), 0);
    sb.push_back(9);
    tick();
    chk("t7_tie2_a", int'(gnt_a), 0);
    chk("t7_tie2_b", int'(gnt_b), 1);
    sb.push_back(10);
    tick();
    req_a = 1'b0;
    req_b = 1'b0;
    wait_drain("t7_tie", 30);
    tick(); tick();
    req_a = 1'b1; cmd_a = 4'd6;
    #1;
    chk("t7_gnt_6", int'(gnt_a), 1);
    sb.push_back(6);
    tick();
    req_a = 1'b0;
    wait_drain("t7_six", 20);
    tick();
    chk("t7_cnt", int'(cmd_cnt), 3 * cnt_exp_const);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lcd_cmd_sched.md
# lcd_cmd_sched

Command scheduler in front of the LCD image controller. Two requesters (host port A, script port B) share the single controller command port; the block arbitrates round-robin, buffers commands in a small FIFO, and issues each as a one-cycle `cmd_valid` pulse only while the controller is not busy. A WRITE command (code 0) is terminal: the scheduler stops accepting commands, waits for the controller's `done`, then asserts `sched_done`.

## Interface
- `DEPTH`, 4: command FIFO entries (power of two, 2..16).
- `CMD_W`, 4: command width; must match the controller.

- `clk`  in  1  clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_a`  in  1  requester A holds a command.
- `cmd_a`  in  CMD_W  requester A command code.
- `gnt_a`  out  1  combinational; A's command accepted this cycle.
- `req_b`, `cmd_b`, `gnt_b`: same as A for requester B.
- `lcd_busy`  in  1  controller busy (image load in progress).
- `lcd_done`  in  1  controller finished image write-back.
- `cmd`  out  CMD_W  registered command to controller.
- `cmd_valid`  out  1  registered one-cycle issue strobe.
- `fifo_full`  out  1  registered; FIFO count == DEPTH.
- `sched_done`  out  1  registered; sequence complete, sticky until reset.
- `cmd_cnt`  out  8  issued-command counter (see Configuration).

## Operation
- Accept window open when: count < DEPTH, `write_seen`==0, state != FINISHED.
- Arbitration: when the window is open and at least one request is present, exactly one gnt asserts. Round-robin on `last` pointer: the requester not granted last wins ties; `last` resets to B, so A wins the first tie.
- Granted command with code 0..11: pushed at the clock edge. Code 12..15: consumed (gnt asserts), dropped, not counted.
- Pushing code 0 sets `write_seen`; all later requests see gnt=0.
- No push when full, even if a pop happens the same cycle. Push and pop in the same cycle when not full: count unchanged.
- Issue FSM:
  - IDLE: if FIFO not empty and `lcd_busy`==0, pop the head, register `cmd`<=head and `cmd_valid`<=1; go to GAP, or to WAIT_DONE if the head is 0.
  - GAP: `cmd_valid`<=0; one cycle; then IDLE.
  - WAIT_DONE: `cmd_valid`<=0; on `lcd_done`==1 go to FINISHED.
  - FINISHED: `sched_done`<=1, FIFO flushed (count<=0), no grants; only reset exits.
- `lcd_busy` rising while the FIFO is not empty: issue stalls in IDLE; contents are held.
- `cmd` holds its last value when `cmd_valid` is 0.

## Timing
- Reset values: `cmd`=0, `cmd_valid`=0, `fifo_full`=0, `sched_done`=0, `cmd_cnt`=0, FIFO empty, `write_seen`=0, `last`=B, state IDLE. `gnt_a`/`gnt_b` evaluate to 0 while reset is held.
- Latency: a grant in cycle T into an empty FIFO with `lcd_busy`=0 gives `cmd_valid` high in cycle T+1, i.e. registered at the end of T+1's IDLE evaluation.
- Issue rate: at most one command every 2 cycles (the GAP cycle).
- `sched_done` asserts the cycle after `lcd_done` is sampled high in WAIT_DONE.
- Reset asserted mid-sequence: all state clears immediately (asynchronously); queued commands are lost.

## Configuration
- `LCD_SCHED_STATS_EN` defined: `cmd_cnt` increments on every `cmd_valid` pulse, including WRITE, and saturates at 255.
- Not defined: `cmd_cnt` is tied to 0 and the counter logic is absent.

## Test plan
- Reset then `lcd_busy`=0; A pushes 4 (RIGHT) at T -> `cmd`=4 and `cmd_valid`=1 for exactly one cycle at T+1; `cmd_cnt`=1 with STATS_EN.
- `req_a`=`req_b`=1 continuously, A sends 1, B sends 2 -> grants alternate A,B,A,B; issued order 1,2,1,2; pulses at least 2 cycles apart.
- `lcd_busy`=1 while pushing 5,6,7,8 -> `fifo_full`=1 after the 4th push; a 5th request gets no grant; `lcd_busy`=0 -> 5,6,7,8 issued in order at 2-cycle spacing.
- B sends 13 -> `gnt_b`=1, no `cmd_valid`, `cmd_cnt` unchanged.
- A sends 7 then 0, then B requests 3 -> B never granted; `cmd`=0 issued; `lcd_done` pulse -> `sched_done`=1 next cycle and stays 1.
- Reset pulled low while in WAIT_DONE -> all outputs at reset values; after release, a new sequence is accepted normally.
